updown_counter_param: RTL

Parametrised, fully synchronous up/down counter. It is the next generation of the team's 4-bit ripple up/down counter. Adds configurable width and modulus, wrap or saturate mode, parallel load, synchronous clear, and a cascadable terminal-count output. All flops share one clock, so there are no ripple edges; it drops into timers, address generators and multi-digit (BCD) counter chains.

---
 rtl/updown_counter_param.sv | 95 +++++++++
 1 files changed

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with wrap/saturate modes, parallel
// load, synchronous clear and a combinational terminal count for cascading.
module updown_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             status,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic             at_top;
  logic             at_zero;
  logic             load_ok;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             sat_nxt;
  logic             load_err_nxt;

  // Boundaries are compared explicitly even when MODULUS fills the full width
  assign at_top  = (count == TOP);
  assign at_zero = (count == '0);
  assign load_ok = ({1'b0, load_val} < MOD_EXT);

  assign tc = en & ~clear & ~load & (status ? at_zero : at_top);

  // Next state: clear beats load beats enable; idle holds count and sat
  always_comb begin
    count_nxt    = count;
    wrap_nxt     = 1'b0;
    sat_nxt      = sat;
    load_err_nxt = 1'b0;
    if (clear) begin
      count_nxt = '0;
      sat_nxt   = 1'b0;
    end else if (load) begin
      sat_nxt = 1'b0;
      if (load_ok) begin
        count_nxt = load_val;
      end else begin
        count_nxt    = TOP;
        load_err_nxt = 1'b1;
      end
    end else if (en) begin
      sat_nxt = 1'b0;
      if (!status) begin
        if (!at_top) begin
          count_nxt = count + WIDTH'(1);
        end else if (SATURATE != 0) begin
          sat_nxt = 1'b1;
        end else begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_nxt = count - WIDTH'(1);
        end else if (SATURATE != 0) begin
          sat_nxt = 1'b1;
        end else begin
          count_nxt = TOP;
          wrap_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      sat      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      wrap     <= wrap_nxt;
      sat      <= sat_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule
